// File: rtl/menu_pkg.sv
// menu_pkg: shared FSM state type, button indices and port-width helper for menu_ctrl
package menu_pkg;

    typedef enum logic [1:0] {IDLE, HELD, LONG} mode_state_t;

    localparam int BTN_MODE  = 0;
    localparam int BTN_SCALE = 1;
    localparam int BTN_HEX   = 2;

    // a select with a single legal value still gets a 1-bit port, held at 0
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner: 2-FF synchroniser, debouncer and registered 1-cycle rise/fall pulses for one raw button
//   clk, reset : system clock, asynchronous active-high reset
//   raw        : asynchronous button input
//   level      : debounced level
//   rise, fall : 1-cycle pulses, one cycle after level changes
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 400_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          s1, s2, level_q;
    logic [CW-1:0] cnt;

    // level follows s2 only after it has differed for DEBOUNCE_CYCLES consecutive cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            s1      <= raw;
            s2      <= s1;
            level_q <= level;
            rise    <= level & ~level_q;
            fall    <= ~level & level_q;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/menu_ctrl.sv
// menu_ctrl: three-button menu controller driving display mode, scale and hex/BCD selects
//   clk, reset   : system clock, asynchronous active-high reset
//   in_mode      : raw mode button (short press advances mode, long press restores defaults)
//   scale_val_in : raw scale button (press advances scale)
//   hex_BCD_in   : raw format button (press toggles hex/BCD)
//   out_sel      : display mode, scale_sel : scale index, hex_BCD_sel : 0 = hex, 1 = BCD
//   sel_changed  : 1-cycle strobe alongside any actual select change
module menu_ctrl import menu_pkg::*; #(
    parameter int   N_MODES           = 12,
    parameter int   N_SCALES          = 4,
    parameter int   DEBOUNCE_CYCLES   = 400_000,
    parameter int   LONG_PRESS_CYCLES = 100_000_000,
    parameter int   DEF_MODE          = 0,
    parameter int   DEF_SCALE         = 0,
    parameter logic DEF_HEX           = 1'b0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_mode,
    input  logic                             scale_val_in,
    input  logic                             hex_BCD_in,
    output logic [clog2_min1(N_MODES)-1:0]   out_sel,
    output logic [clog2_min1(N_SCALES)-1:0]  scale_sel,
    output logic                             hex_BCD_sel,
    output logic                             sel_changed
);

    localparam int MW = clog2_min1(N_MODES);
    localparam int SW = clog2_min1(N_SCALES);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);

    logic [2:0]    raw_b, lvl, rise, fall;
    logic          unused;
    mode_state_t   state, state_n;
    logic [HW-1:0] hold_cnt;
    logic          restore, advance;
    logic [MW-1:0] mode_n;
    logic [SW-1:0] scale_n;
    logic          hex_n;

    assign raw_b  = {hex_BCD_in, scale_val_in, in_mode};
    assign unused = ^{lvl, fall[BTN_SCALE], fall[BTN_HEX]};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk   (clk),
            .reset (reset),
            .raw   (raw_b[i]),
            .level (lvl[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    // a release arriving in the same cycle the hold count tops out counts as a long press
    always_comb begin
        state_n = state;
        restore = 1'b0;
        advance = 1'b0;
        case (state)
            IDLE: state_n = rise[BTN_MODE] ? HELD : IDLE;
            HELD: begin
                restore = (hold_cnt == HW'(LONG_PRESS_CYCLES - 1));
                advance = !restore && fall[BTN_MODE];
                state_n = restore ? LONG : advance ? IDLE : HELD;
            end
            LONG:    state_n = fall[BTN_MODE] ? IDLE : LONG;
            default: state_n = IDLE;
        endcase
        mode_n  = restore ? MW'(DEF_MODE) :
                  advance ? ((out_sel == MW'(N_MODES - 1)) ? '0 : out_sel + 1'b1) : out_sel;
        scale_n = restore ? SW'(DEF_SCALE) :
                  rise[BTN_SCALE] ? ((scale_sel == SW'(N_SCALES - 1)) ? '0 : scale_sel + 1'b1) : scale_sel;
        hex_n   = restore ? DEF_HEX : hex_BCD_sel ^ rise[BTN_HEX];
    end

    // hold counter clears in IDLE, counts in HELD and saturates once LONG is reached
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            out_sel     <= MW'(DEF_MODE);
            scale_sel   <= SW'(DEF_SCALE);
            hex_BCD_sel <= DEF_HEX;
            sel_changed <= 1'b0;
        end else begin
            state       <= state_n;
            hold_cnt    <= (state == IDLE) ? '0 : (state == HELD && !restore) ? hold_cnt + 1'b1 : hold_cnt;
            out_sel     <= mode_n;
            scale_sel   <= scale_n;
            hex_BCD_sel <= hex_n;
            sel_changed <= {mode_n, scale_n, hex_n} != {out_sel, scale_sel, hex_BCD_sel};
        end
    end

endmodule

// File: tb/tb_menu_ctrl.sv
// tb_menu_ctrl: directed self-checking bench for menu_ctrl with short debounce and long-press timings
module tb_menu_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] btn = 3'b000;
    logic [3:0] out_sel;
    logic [1:0] scale_sel;
    logic       hex_BCD_sel;
    logic       sel_changed;
    int         vecs = 0;
    int         errs = 0;
    int         strobes = 0;

    menu_ctrl #(
        .N_MODES(12), .N_SCALES(4), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20),
        .DEF_MODE(0), .DEF_SCALE(0), .DEF_HEX(1'b0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_mode      (btn[0]),
        .scale_val_in (btn[1]),
        .hex_BCD_in   (btn[2]),
        .out_sel      (out_sel),
        .scale_sel    (scale_sel),
        .hex_BCD_sel  (hex_BCD_sel),
        .sel_changed  (sel_changed)
    );

    always #5 clk = ~clk;

    // tally every strobe, sampled just after the edge that produced it
    always @(posedge clk) begin
        #1;
        if (sel_changed === 1'b1) strobes++;
    end

    // inputs are driven and outputs checked on the falling edge
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // raw edge driven at a falling edge is sampled on the next rising edge (edge 1);
    // the resulting select change and strobe land on edge 8 (2 sync + 4 debounce + 1 pulse + 1 update)
    task automatic press(input int b);
        btn[b] = 1'b1;
        cyc(8);
        btn[b] = 1'b0;
        cyc(8);
    endtask

    task automatic test_reset();
        cyc(2);
        vecs++;
        if (out_sel !== 4'd0 || scale_sel !== 2'd0 || hex_BCD_sel !== 1'b0 || sel_changed !== 1'b0) begin
            errs++;
            $display("FAIL reset: got %0d/%0d/%0d/%0d want 0/0/0/0", out_sel, scale_sel, hex_BCD_sel, sel_changed);
        end
        reset = 1'b0;
        cyc(2);
    endtask

    task automatic test_bounce();
        int s;
        s = strobes;
        for (int i = 0; i < 10; i++) begin
            btn[0] = ~btn[0];
            cyc(1);
        end
        cyc(20);
        vecs++;
        if (out_sel !== 4'd0) begin
            errs++;
            $display("FAIL bounce_mode: got %0d want 0", out_sel);
        end
        vecs++;
        if (strobes !== s) begin
            errs++;
            $display("FAIL bounce_strobe: got %0d strobes want 0", strobes - s);
        end
    endtask

    task automatic test_short_presses();
        int exp_m;
        int s;
        exp_m = 0;
        for (int k = 0; k < 12; k++) begin
            s = strobes;
            btn[0] = 1'b1;
            cyc(8);
            btn[0] = 1'b0;
            cyc(7);
            vecs++;
            if (out_sel !== 4'(exp_m) || strobes !== s) begin
                errs++;
                $display("FAIL short_early[%0d]: got mode %0d strobes %0d want %0d/0", k, out_sel, strobes - s, exp_m);
            end
            exp_m = (exp_m + 1) % 12;
            cyc(1);
            vecs++;
            if (out_sel !== 4'(exp_m) || strobes !== s + 1 || sel_changed !== 1'b1) begin
                errs++;
                $display("FAIL short_step[%0d]: got mode %0d strobes %0d sc %0d want %0d/1/1", k, out_sel, strobes - s, sel_changed, exp_m);
            end
        end
    endtask

    task automatic test_scale_hex();
        int exp_s;
        logic exp_h;
        int s;
        exp_s = 0;
        for (int k = 0; k < 4; k++) begin
            press(1);
            exp_s = (exp_s + 1) % 4;
            vecs++;
            if (scale_sel !== 2'(exp_s)) begin
                errs++;
                $display("FAIL scale[%0d]: got %0d want %0d", k, scale_sel, exp_s);
            end
        end
        exp_h = 1'b0;
        for (int k = 0; k < 2; k++) begin
            press(2);
            exp_h = ~exp_h;
            vecs++;
            if (hex_BCD_sel !== exp_h) begin
                errs++;
                $display("FAIL hex[%0d]: got %0d want %0d", k, hex_BCD_sel, exp_h);
            end
        end
        s = strobes;
        btn[1] = 1'b1;
        btn[2] = 1'b1;
        cyc(7);
        vecs++;
        if (scale_sel !== 2'd0 || hex_BCD_sel !== 1'b0) begin
            errs++;
            $display("FAIL both_early: got %0d/%0d want 0/0", scale_sel, hex_BCD_sel);
        end
        cyc(1);
        vecs++;
        if (scale_sel !== 2'd1 || hex_BCD_sel !== 1'b1 || strobes !== s + 1) begin
            errs++;
            $display("FAIL both_step: got %0d/%0d strobes %0d want 1/1/1", scale_sel, hex_BCD_sel, strobes - s);
        end
        cyc(1);
        vecs++;
        if (sel_changed !== 1'b0) begin
            errs++;
            $display("FAIL both_strobe_width: got %0d want 0", sel_changed);
        end
        btn[1] = 1'b0;
        btn[2] = 1'b0;
        cyc(16);
        vecs++;
        if (strobes !== s + 1 || scale_sel !== 2'd1 || hex_BCD_sel !== 1'b1) begin
            errs++;
            $display("FAIL both_release: got %0d/%0d strobes %0d want 1/1/1", scale_sel, hex_BCD_sel, strobes - s);
        end
    endtask

    // restore lands on edge 28: pulse on 7, HELD with count 0 on 8, count 19 on 27
    task automatic test_long_press();
        int s;
        for (int k = 0; k < 5; k++) press(0);
        press(1);
        vecs++;
        if (out_sel !== 4'd5 || scale_sel !== 2'd2 || hex_BCD_sel !== 1'b1) begin
            errs++;
            $display("FAIL long_setup: got %0d/%0d/%0d want 5/2/1", out_sel, scale_sel, hex_BCD_sel);
        end
        s = strobes;
        btn[0] = 1'b1;
        cyc(27);
        vecs++;
        if (out_sel !== 4'd5 || scale_sel !== 2'd2 || hex_BCD_sel !== 1'b1 || strobes !== s) begin
            errs++;
            $display("FAIL long_early: got %0d/%0d/%0d strobes %0d want 5/2/1/0", out_sel, scale_sel, hex_BCD_sel, strobes - s);
        end
        cyc(1);
        vecs++;
        if (out_sel !== 4'd0 || scale_sel !== 2'd0 || hex_BCD_sel !== 1'b0 || strobes !== s + 1) begin
            errs++;
            $display("FAIL long_restore: got %0d/%0d/%0d strobes %0d want 0/0/0/1", out_sel, scale_sel, hex_BCD_sel, strobes - s);
        end
        cyc(12);
        btn[0] = 1'b0;
        cyc(20);
        vecs++;
        if (out_sel !== 4'd0 || strobes !== s + 1) begin
            errs++;
            $display("FAIL long_release: got mode %0d strobes %0d want 0/1", out_sel, strobes - s);
        end
    endtask

    task automatic test_reset_mid_press();
        int s;
        press(0);
        btn[0] = 1'b1;
        cyc(10);
        vecs++;
        if (out_sel !== 4'd1) begin
            errs++;
            $display("FAIL midpress_setup: got %0d want 1", out_sel);
        end
        #2;
        reset = 1'b1;
        #1;
        vecs++;
        if (out_sel !== 4'd0 || scale_sel !== 2'd0 || hex_BCD_sel !== 1'b0 || sel_changed !== 1'b0) begin
            errs++;
            $display("FAIL midpress_reset: got %0d/%0d/%0d/%0d want 0/0/0/0", out_sel, scale_sel, hex_BCD_sel, sel_changed);
        end
        cyc(1);
        reset = 1'b0;
        s = strobes;
        cyc(1);
        btn[0] = 1'b0;
        cyc(20);
        vecs++;
        if (out_sel !== 4'd0 || strobes !== s) begin
            errs++;
            $display("FAIL midpress_release: got mode %0d strobes %0d want 0/0", out_sel, strobes - s);
        end
    endtask

    // scale raw rises at 20 so its pulse (edge 20+7) arrives in the restore cycle
    task automatic test_restore_override();
        int s;
        s = strobes;
        btn[0] = 1'b1;
        cyc(20);
        btn[1] = 1'b1;
        cyc(8);
        vecs++;
        if (scale_sel !== 2'd0 || strobes !== s) begin
            errs++;
            $display("FAIL override_restore: got scale %0d strobes %0d want 0/0", scale_sel, strobes - s);
        end
        cyc(12);
        btn[0] = 1'b0;
        btn[1] = 1'b0;
        cyc(20);
        vecs++;
        if (scale_sel !== 2'd0 || out_sel !== 4'd0 || strobes !== s) begin
            errs++;
            $display("FAIL override_after: got %0d/%0d strobes %0d want 0/0/0", out_sel, scale_sel, strobes - s);
        end
        btn[0] = 1'b1;
        cyc(40);
        btn[0] = 1'b0;
        cyc(20);
        vecs++;
        if (strobes !== s || out_sel !== 4'd0) begin
            errs++;
            $display("FAIL restore_at_defaults: got mode %0d strobes %0d want 0/0", out_sel, strobes - s);
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_short_presses();
        test_scale_hex();
        test_long_press();
        test_reset_mid_press();
        test_restore_override();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
